// File: rtl/collision_monitor.sv
// Per-frame player/obstacle overlap detection driving lives, score and the idle/play/grace/over game FSM.
// Define COLLISION_GRACE_EN to build the post-hit GRACE invulnerability window; without it a non-fatal hit returns straight to PLAY.
module collision_monitor #(
    parameter int PLAYER_X     = 100,
    parameter int PLAYER_W     = 20,
    parameter int OBST_W       = 15,
    parameter int OBST_H       = 30,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [9:0]  jump_height,
    input  logic [9:0]  obstacle_x,
    input  logic        obstacle_valid,
    output logic        hit,
    output logic [2:0]  lives,
    output logic [13:0] score,
    output logic        playing,
    output logic        game_over
);

    if (LIVES < 1 || LIVES > 7 || GRACE_FRAMES < 1 || GRACE_FRAMES > 255) begin : g_param_check
        $error("collision_monitor: LIVES or GRACE_FRAMES out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GRACE, S_OVER} state_t;

    localparam logic [10:0] P_LEFT     = 11'(PLAYER_X);
    localparam logic [10:0] P_RIGHT    = 11'(PLAYER_X + PLAYER_W);
    localparam logic [10:0] O_WIDTH    = 11'(OBST_W);
    localparam logic [9:0]  O_HEIGHT   = 10'(OBST_H);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
    localparam logic [13:0] SCORE_MAX  = 14'd9999;

    function automatic logic [13:0] sat_inc(input logic [13:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 14'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hit_q, hit_d;
    logic [2:0]  lives_q, lives_d;
    logic [13:0] score_q, score_d;
    logic        hit_seen_q, hit_seen_d;
    logic        scored_q, scored_d;
    logic        playing_q, playing_d;
    logic        game_over_q, game_over_d;
`ifdef COLLISION_GRACE_EN
    localparam logic [7:0] GRACE_LAST = 8'(GRACE_FRAMES - 1);
    logic [7:0]  grace_cnt_q, grace_cnt_d;
`endif

    // Geometry in 11 bits so obstacle_x + OBST_W cannot wrap.
    logic [10:0] obst_l, obst_r;
    logic        collide, passed, respawn;

    assign obst_l  = {1'b0, obstacle_x};
    assign obst_r  = obst_l + O_WIDTH;
    assign collide = obstacle_valid && (obst_l < P_RIGHT) && (obst_r > P_LEFT)
                     && (jump_height < O_HEIGHT);
    assign passed  = obstacle_valid && (obst_r <= P_LEFT);
    assign respawn = !obstacle_valid || (obst_l >= P_RIGHT);

    always_comb begin
        state_d    = state_q;
        hit_d      = 1'b0;
        lives_d    = lives_q;
        score_d    = score_q;
        hit_seen_d = hit_seen_q;
        scored_d   = scored_q;
`ifdef COLLISION_GRACE_EN
        grace_cnt_d = grace_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d    = S_PLAY;
                    lives_d    = LIVES_INIT;
                    score_d    = '0;
                    hit_seen_d = 1'b0;
                    scored_d   = 1'b0;
`ifdef COLLISION_GRACE_EN
                    grace_cnt_d = '0;
`endif
                end
            end
            S_PLAY, S_GRACE: begin
                if (frame_tick) begin
                    if (respawn) begin
                        hit_seen_d = 1'b0;
                        scored_d   = 1'b0;
                    end
                    // Collisions only count in PLAY; a collided obstacle can never score.
                    if (state_q == S_PLAY && collide && !hit_seen_q) begin
                        hit_d      = 1'b1;
                        hit_seen_d = 1'b1;
                        lives_d    = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        if (lives_d == 3'd0) state_d = S_OVER;
`ifdef COLLISION_GRACE_EN
                        else begin
                            state_d     = S_GRACE;
                            grace_cnt_d = '0;
                        end
`endif
                    end else if (passed && !hit_seen_q && !scored_q) begin
                        score_d  = sat_inc(score_q);
                        scored_d = 1'b1;
                    end
`ifdef COLLISION_GRACE_EN
                    if (state_q == S_GRACE) begin
                        if (grace_cnt_q == GRACE_LAST) state_d = S_PLAY;
                        else grace_cnt_d = grace_cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        playing_d   = (state_d == S_PLAY) || (state_d == S_GRACE);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hit_q       <= 1'b0;
            lives_q     <= LIVES_INIT;
            score_q     <= '0;
            hit_seen_q  <= 1'b0;
            scored_q    <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
`ifdef COLLISION_GRACE_EN
            grace_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            hit_seen_q  <= hit_seen_d;
            scored_q    <= scored_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
`ifdef COLLISION_GRACE_EN
            grace_cnt_q <= grace_cnt_d;
`endif
        end
    end

    assign hit       = hit_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Bench for collision_monitor: directed vector table, score saturation run, and randomized frames against a rule-level model.
module tb_collision_monitor;

    localparam int PX = 100;
    localparam int PW = 20;
    localparam int OW = 15;
    localparam int OH = 30;
    localparam int NL = 3;
    localparam int GF = 2;
`ifdef COLLISION_GRACE_EN
    localparam bit GRACE_ON = 1'b1;
`else
    localparam bit GRACE_ON = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_GRACE = 2;
    localparam int M_OVER  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  jump_height = '0;
    logic [9:0]  obstacle_x = '0;
    logic        obstacle_valid = 1'b0;
    logic        hit;
    logic [2:0]  lives;
    logic [13:0] score;
    logic        playing;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    collision_monitor #(
        .PLAYER_X(PX), .PLAYER_W(PW), .OBST_W(OW), .OBST_H(OH),
        .LIVES(NL), .GRACE_FRAMES(GF)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .jump_height(jump_height), .obstacle_x(obstacle_x),
        .obstacle_valid(obstacle_valid), .hit(hit), .lives(lives),
        .score(score), .playing(playing), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference model: game state as plain integers, advanced once per clock.
    int m_state = M_IDLE;
    int m_lives = NL;
    int m_score = 0;
    int m_grace_ticks = 0;
    bit m_hit_seen = 1'b0;
    bit m_scored = 1'b0;
    bit m_hit = 1'b0;

    task automatic model(input bit r, input bit st, input bit ft, input int jh, input int ox, input bit ov);
        int right;
        bit col, pass, was_grace;
        right = ox + OW;
        col = ov && (ox < PX + PW) && (right > PX) && (jh < OH);
        pass = ov && (right <= PX);
        was_grace = (m_state == M_GRACE);
        m_hit = 1'b0;
        if (r) begin
            m_state = M_IDLE; m_lives = NL; m_score = 0; m_grace_ticks = 0;
            m_hit_seen = 1'b0; m_scored = 1'b0;
        end else if (m_state == M_IDLE || m_state == M_OVER) begin
            if (st) begin
                m_state = M_PLAY; m_lives = NL; m_score = 0;
                m_hit_seen = 1'b0; m_scored = 1'b0;
            end
        end else if (ft) begin
            if (!ov || ox >= PX + PW) begin
                m_hit_seen = 1'b0; m_scored = 1'b0;
            end
            if (!was_grace && col && !m_hit_seen) begin
                m_hit = 1'b1; m_hit_seen = 1'b1; m_lives = m_lives - 1;
                if (m_lives == 0) m_state = M_OVER;
                else if (GRACE_ON) begin
                    m_state = M_GRACE; m_grace_ticks = 0;
                end
            end else if (pass && !m_hit_seen && !m_scored) begin
                if (m_score < 9999) m_score = m_score + 1;
                m_scored = 1'b1;
            end
            if (was_grace) begin
                m_grace_ticks = m_grace_ticks + 1;
                if (m_grace_ticks >= GF) m_state = M_PLAY;
            end
        end
    endtask

    task automatic step(input bit r, input bit st, input bit ft, input int jh, input int ox, input bit ov);
        reset = r; start = st; frame_tick = ft;
        jump_height = 10'(jh); obstacle_x = 10'(ox); obstacle_valid = ov;
        model(r, st, ft, jh, ox, ov);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input bit eh, input int el, input int es, input bit ep, input bit eo);
        checks++;
        if (hit !== eh || lives !== 3'(el) || score !== 14'(es) || playing !== ep || game_over !== eo) begin
            errors++;
            $display("FAIL %s: got hit=%0b lives=%0d score=%0d playing=%0b game_over=%0b, expected hit=%0b lives=%0d score=%0d playing=%0b game_over=%0b",
                     nm, hit, lives, score, playing, game_over, eh, el, es, ep, eo);
        end
    endtask

    typedef struct {
        bit rst; bit st; bit ft; int jh; int ox; bit ov;
        bit e_hit; int e_lives; int e_score; bit e_play; bit e_over;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit st, input bit ft, input int jh, input int ox, input bit ov,
                       input bit eh, input int el, input int es, input bit ep, input bit eo);
        vec_t v;
        v.rst = r; v.st = st; v.ft = ft; v.jh = jh; v.ox = ox; v.ov = ov;
        v.e_hit = eh; v.e_lives = el; v.e_score = es; v.e_play = ep; v.e_over = eo;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset, idle tick ignored, start.
        add(1, 0, 0, 0, 200, 1,  0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 110, 1,  0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        // Grounded sweep: single hit at x=110, no score.
        for (int x = 200; x >= 0; x -= 10)
            add(0, 0, 1, 0, x, 1,  (x == 110), (x <= 110) ? 2 : 3, 0, 1, 0);
        // Jumping sweep: no hit, one point at x=80.
        for (int x = 200; x >= 0; x -= 10)
            add(0, 0, 1, 45, x, 1,  0, 2, (x <= 80) ? 1 : 0, 1, 0);
        // Three hits to game over, frozen while over, restart.
        add(1, 0, 0, 0, 200, 1,  0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 80, 1,   0, 3, 1, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 3, 1, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 2, 1, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 2, 1, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 2, 1, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 1, 1, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 0, 1, 0, 1);
        add(0, 0, 1, 0, 200, 1,  0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 80, 1,   0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 110, 1,  0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 110, 1,  0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 2, 0, 1, 0);
        // Second obstacle overlapping inside the grace window.
        add(1, 0, 0, 0, 200, 1,  0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 2, 0, 1, 0);
        add(0, 0, 1, 0, 200, 1,  0, 2, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  GRACE_ON ? 0 : 1, GRACE_ON ? 2 : 1, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  GRACE_ON ? 1 : 0, 1, 0, 1, 0);
        // Reset while in grace with a colliding frame tick.
        add(1, 0, 0, 0, 200, 1,  0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 2, 0, 1, 0);
        add(1, 0, 1, 0, 110, 1,  0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 110, 1,  0, 3, 0, 0, 0);
        add(0, 1, 0, 0, 200, 1,  0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 110, 1,  1, 2, 0, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].ft, tbl[i].jh, tbl[i].ox, tbl[i].ov);
            check($sformatf("vec[%0d]", i), tbl[i].e_hit, tbl[i].e_lives, tbl[i].e_score,
                  tbl[i].e_play, tbl[i].e_over);
        end

        // Score saturation at 9999.
        step(1, 0, 0, 0, 200, 1);
        step(0, 1, 0, 0, 200, 1);
        for (int n = 0; n < 9999; n++) begin
            step(0, 0, 1, 0, 200, 1);
            step(0, 0, 1, 0, 0, 1);
        end
        check("score_reach_9999", 0, 3, 9999, 1, 0);
        step(0, 0, 1, 0, 200, 1);
        step(0, 0, 1, 0, 0, 1);
        check("score_hold_9999", 0, 3, 9999, 1, 0);

        // Randomized frames against the model.
        step(1, 0, 0, 0, 200, 1);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0, int'($urandom_range(0, 60)),
                 int'($urandom_range(0, 250)), $urandom_range(0, 7) != 0);
            check($sformatf("rand[%0d]", i), m_hit, m_lives, m_score,
                  (m_state == M_PLAY) || (m_state == M_GRACE), m_state == M_OVER);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
